mem_burst_master: RTL and testbench
===================================

// Module: mem_burst_master
// PURPOSE
//  Initiator side of the byte-wide RAM access interface. Moves a burst of LENGTH bytes between a
//  valid/ready byte stream and the RAM: stream-to-RAM (load image/kernel data) or RAM-to-stream
//  (unload results). It drives read/write strobes, address and data, and uses the RAM's done flags
//  to pace each access. It sits between the IO stream logic and the RAM.
// PARAMETERS
//  ADDR_W     16     address width
//  DATA_W     8      data width
//  MEM_DEPTH  32768  addressable bytes; a burst must stay below this
//  TIMEOUT    15     max cycles a request is held waiting for done before error
// PORTS
//  clk              in   1       clock, all logic on posedge
//  RST              in   1       synchronous reset, active-low (0 = reset)
//  start            in   1       one-cycle command strobe, sampled only in IDLE
//  dir              in   1       0 = stream->RAM write, 1 = RAM->stream read; captured on start
//  base_addr        in   ADDR_W  first byte address; captured on start
//  length           in   ADDR_W  byte count; captured on start
//  busy             out  1       high from the cycle after an accepted start through FINISH
//  done             out  1       one-cycle pulse: burst completed, or aborted with error
//  error            out  1       sticky until next accepted start or reset: range fault or timeout
//  in_data          in   DATA_W  write-stream byte
//  in_valid         in   1       write-stream byte available
//  in_ready         out  1       master accepts in_data this cycle
//  out_data         out  DATA_W  read-stream byte
//  out_valid        out  1       out_data valid; held with data stable until out_ready
//  out_ready        in   1       consumer accepts out_data
//  mem_address      out  ADDR_W  RAM address
//  mem_data         out  DATA_W  RAM write data
//  mem_read_signal  out  1       RAM read request
//  mem_write_signal out  1       RAM write request
//  mem_dataout      in   DATA_W  RAM read data
//  mem_doneRead     in   1       RAM read complete
//  mem_doneWrite    in   1       RAM write complete
// BEHAVIOUR
//  Reset (RST=0 at a posedge): state IDLE; every output 0 (busy, done, error, in_ready, out_valid,
//   out_data, mem_*). This holds even mid-burst: any request is dropped at that edge.
//  States: IDLE, CHECK, FETCH, WREQ, RREQ, RSEND, FINISH.
//  IDLE: start=1 -> capture dir/base/length, clear error, counter=0 -> CHECK. start outside IDLE ignored.
//  CHECK (1 cycle): length==0 -> FINISH without RAM access; base+length > MEM_DEPTH (17-bit
//   compare, no wrap) -> error=1, FINISH without RAM access; else dir=0 -> FETCH, dir=1 -> RREQ.
//  FETCH: in_ready=1; on in_valid&in_ready latch in_data -> WREQ. No in_ready elsewhere.
//  WREQ: mem_write_signal=1, mem_address=base+counter, mem_data=latched byte, all held stable.
//   mem_doneWrite=1 at a posedge completes the write: counter++, then counter==length ? FINISH : FETCH.
//  RREQ: mem_read_signal=1, mem_address=base+counter. mem_doneRead=1 at a posedge latches
//   mem_dataout into out_data -> RSEND.
//  RSEND: out_valid=1; out_data is stable; on out_ready: counter++, then FINISH if counter==length,
//   else RREQ.
//  Strobes are mutually exclusive. Each strobe is deasserted in the cycle after done is sampled.
//   The RAM acts on negedge, so an access normally completes in 1 cycle.
//  Timeout: a cycle counter runs in WREQ/RREQ. Done still low after TIMEOUT cycles ->
//   drop strobe, error=1 -> FINISH.
//  FINISH: done=1 for one cycle, busy still 1 -> IDLE. Best throughput is 2 cycles/byte.
//  Address arithmetic is ADDR_W bits. The CHECK stage guarantees no wrap during the burst.
// TESTING
//  1 dir=0 base=0x0100 len=3, stream A1,B2,C3, RAM model -> RAM[0x100..0x102]=A1,B2,C3; one done pulse; error=0.
//  2 dir=1 over same range, out_ready low 4 cycles per byte -> out_data A1,B2,C3 in order, each held stable; done once.
//  3 len=0 -> done 2 cycles after start, no strobe ever high; base=0x7FFF len=2 -> error=1, done, no strobe.
//  4 mem_doneWrite tied 0, len=1 -> strobe held TIMEOUT=15 cycles, then dropped; error=1; done pulse.
//  5 RST=0 during WREQ of byte 2 of 4 -> next edge all outputs 0, IDLE; new start runs normally.
//  6 start pulsed while busy -> ignored; in_valid held high in RREQ -> in_ready stays 0.

Source files
------------

// File: rtl/mem_burst_master.sv
// mem_burst_master
//   Initiator for the byte-wide RAM access interface. Moves a burst of
//   'length' bytes either from a valid/ready input stream into RAM
//   (dir=0) or from RAM out to a valid/ready output stream (dir=1).
//   Each RAM access is paced by the RAM's done flags and guarded by a
//   timeout.
//
// Ports
//   clk, RST             clock / synchronous active-low reset
//   start, dir           command strobe (sampled in IDLE) and direction
//   base_addr, length    burst start address and byte count
//   busy, done, error    burst status (done pulses once, error is sticky)
//   in_data/valid/ready  write-direction byte stream (master is sink)
//   out_data/valid/ready read-direction byte stream (master is source)
//   mem_address, mem_data, mem_read_signal, mem_write_signal
//                        RAM request side
//   mem_dataout, mem_doneRead, mem_doneWrite
//                        RAM response side
module mem_burst_master #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 32768,
  parameter int TIMEOUT   = 15
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic              dir,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] length,
  output logic              busy,
  output logic              done,
  output logic              error,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data,
  output logic              mem_read_signal,
  output logic              mem_write_signal,
  input  logic [DATA_W-1:0] mem_dataout,
  input  logic              mem_doneRead,
  input  logic              mem_doneWrite
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);
  // One extra bit so base+length can be compared against the depth without wrapping.
  localparam logic [ADDR_W:0] DEPTH_LIM = (ADDR_W + 1)'(MEM_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_FETCH, S_WREQ, S_RREQ, S_RSEND, S_FINISH
  } state_t;

  state_t            state_reg, state_next;
  logic              dir_reg;
  logic [ADDR_W-1:0] base_reg, len_reg, cnt_reg;
  logic [DATA_W-1:0] wbyte_reg, rbyte_reg;
  logic              error_reg;
  logic [TMO_W-1:0]  tmo_reg;

  logic [ADDR_W:0]   span;
  logic              range_fault;
  logic [ADDR_W-1:0] cnt_inc;
  logic              last_byte;
  logic              tmo_expired;

  assign span        = {1'b0, base_reg} + {1'b0, len_reg};
  assign range_fault = span > DEPTH_LIM;
  assign cnt_inc     = cnt_reg + ADDR_W'(1);
  assign last_byte   = cnt_inc == len_reg;
  // The request has then been held for TIMEOUT cycles without a done.
  assign tmo_expired = tmo_reg == TMO_W'(TIMEOUT - 1);

  // State register
  always_ff @(posedge clk) begin
    if (!RST) state_reg <= S_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start) state_next = S_CHECK;
      S_CHECK: begin
        if (len_reg == '0 || range_fault) state_next = S_FINISH;
        else if (dir_reg)                 state_next = S_RREQ;
        else                              state_next = S_FETCH;
      end
      S_FETCH:  if (in_valid) state_next = S_WREQ;
      S_WREQ: begin
        if (mem_doneWrite)    state_next = last_byte ? S_FINISH : S_FETCH;
        else if (tmo_expired) state_next = S_FINISH;
      end
      S_RREQ: begin
        if (mem_doneRead)     state_next = S_RSEND;
        else if (tmo_expired) state_next = S_FINISH;
      end
      S_RSEND:  if (out_ready) state_next = last_byte ? S_FINISH : S_RREQ;
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // Burst datapath: command capture, byte counter, data latches, timeout, error
  always_ff @(posedge clk) begin
    if (!RST) begin
      dir_reg   <= 1'b0;
      base_reg  <= '0;
      len_reg   <= '0;
      cnt_reg   <= '0;
      wbyte_reg <= '0;
      rbyte_reg <= '0;
      error_reg <= 1'b0;
      tmo_reg   <= '0;
    end else begin
      tmo_reg <= '0;
      case (state_reg)
        S_IDLE: begin
          if (start) begin
            dir_reg   <= dir;
            base_reg  <= base_addr;
            len_reg   <= length;
            cnt_reg   <= '0;
            error_reg <= 1'b0;
          end
        end
        S_CHECK: if (len_reg != '0 && range_fault) error_reg <= 1'b1;
        S_FETCH: if (in_valid) wbyte_reg <= in_data;
        S_WREQ: begin
          if (mem_doneWrite)    cnt_reg   <= cnt_inc;
          else if (tmo_expired) error_reg <= 1'b1;
          else                  tmo_reg   <= tmo_reg + TMO_W'(1);
        end
        S_RREQ: begin
          if (mem_doneRead)     rbyte_reg <= mem_dataout;
          else if (tmo_expired) error_reg <= 1'b1;
          else                  tmo_reg   <= tmo_reg + TMO_W'(1);
        end
        S_RSEND: if (out_ready) cnt_reg <= cnt_inc;
        default: ;
      endcase
    end
  end

  // Outputs decoded from state; address/data are zeroed outside a request
  always_comb begin
    busy             = state_reg != S_IDLE;
    done             = state_reg == S_FINISH;
    error            = error_reg;
    in_ready         = state_reg == S_FETCH;
    out_valid        = state_reg == S_RSEND;
    out_data         = rbyte_reg;
    mem_write_signal = state_reg == S_WREQ;
    mem_read_signal  = state_reg == S_RREQ;
    mem_address      = '0;
    mem_data         = '0;
    if (state_reg == S_WREQ || state_reg == S_RREQ) mem_address = base_reg + cnt_reg;
    if (state_reg == S_WREQ) mem_data = wbyte_reg;
  end

endmodule

// File: tb/tb_mem_burst_master.sv
// Testbench for mem_burst_master: RAM model acting on negedge, stream
// producer/consumer driven on negedge, reference memory image kept in the
// bench and compared per burst.
module tb_mem_burst_master;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 8;
  localparam int MEM_DEPTH = 32768;
  localparam int TIMEOUT   = 15;

  logic              clk = 1'b0;
  logic              RST = 1'b0;
  logic              start = 1'b0;
  logic              dir = 1'b0;
  logic [ADDR_W-1:0] base_addr = '0;
  logic [ADDR_W-1:0] length = '0;
  logic              busy, done, error;
  logic [DATA_W-1:0] in_data = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_data;
  logic              mem_read_signal, mem_write_signal;
  logic [DATA_W-1:0] mem_dataout = '0;
  logic              mem_doneRead = 1'b0;
  logic              mem_doneWrite = 1'b0;

  mem_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(MEM_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .RST(RST), .start(start), .dir(dir),
    .base_addr(base_addr), .length(length),
    .busy(busy), .done(done), .error(error),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .mem_address(mem_address), .mem_data(mem_data),
    .mem_read_signal(mem_read_signal), .mem_write_signal(mem_write_signal),
    .mem_dataout(mem_dataout), .mem_doneRead(mem_doneRead), .mem_doneWrite(mem_doneWrite)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int i);
    return 8'((i * 151) ^ (i >> 5));
  endfunction

  // Bench RAM (written by the DUT) and the image it should hold
  logic [7:0] tb_ram  [0:65535];
  logic [7:0] ref_mem [0:65535];

  bit hang      = 1'b0;   // RAM never answers
  int fixed_lat = -1;     // >=0: fixed extra wait cycles, else random 0..2

  bit ram_init_done = 1'b0;
  int wait_cnt = 0;
  always @(negedge clk) begin
    if (!ram_init_done) begin
      for (int i = 0; i < 65536; i++) tb_ram[i] = pat(i);
      ram_init_done = 1'b1;
    end
    if (mem_write_signal || mem_read_signal) begin
      if (mem_write_signal && mem_read_signal) check("strobe_excl", 32'd1, 32'd0);
      if (!hang) begin
        if (wait_cnt == 0) begin
          if (mem_write_signal) begin
            tb_ram[mem_address] = mem_data;
            mem_doneWrite = 1'b1;
          end else begin
            mem_dataout  = tb_ram[mem_address];
            mem_doneRead = 1'b1;
          end
        end else begin
          wait_cnt--;
        end
      end
    end else begin
      mem_doneWrite = 1'b0;
      mem_doneRead  = 1'b0;
      wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
    end
  end

  task automatic all_zero(input string tag);
    check({tag, "_ctl"}, 32'({busy, done, error, in_ready, out_valid,
                              mem_read_signal, mem_write_signal}), 32'd0);
    check({tag, "_data"}, {out_data, mem_data, mem_address}, 32'd0);
  endtask

  // One complete burst with bench-side expectations.
  task automatic run_burst(input bit d, input logic [15:0] b, input logic [15:0] l,
                           input bit spurious, input bit stall4, input bit abc);
    logic [7:0] acc[$];
    logic [7:0] held = '0;
    bit have_held = 1'b0;
    int cyc = 0, done_cyc = -1, done_cnt = 0, strobe_cyc = 0, idx = 0, stall = 0;
    bit dry, exp_err;
    dry     = (l == 0) || (int'(b) + int'(l) > MEM_DEPTH);
    exp_err = ((l != 0) && (int'(b) + int'(l) > MEM_DEPTH)) || hang;
    @(negedge clk);
    dir = d; base_addr = b; length = l; start = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    while (1) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      if (cyc == 1) begin
        check("busy_rise", 32'(busy), 32'd1);
        check("err_clear", 32'(error), 32'd0);
      end
      if (mem_write_signal || mem_read_signal) strobe_cyc++;
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = cyc;
        check("busy_in_done", 32'(busy), 32'd1);
      end
      if (done_cnt > 0 && !done && !busy) break;
      if (cyc > 3000) begin
        check("burst_bound", 32'd0, 32'd1);
        break;
      end
      if (spurious && busy && $urandom_range(0, 3) == 0) start = 1'b1;
      if (!d) begin
        in_valid = $urandom_range(0, 3) != 0;
        in_data  = abc ? 8'(8'hA1 + acc.size() * 8'h11) : 8'($urandom);
        if (in_valid && in_ready) acc.push_back(in_data);
      end else begin
        in_valid = 1'b1;
        in_data  = 8'($urandom);
        if (in_ready) check("rd_in_ready", 32'(in_ready), 32'd0);
        if (have_held) begin
          check("rs_valid_hold", 32'(out_valid), 32'd1);
          check("rs_data_hold", 32'(out_data), 32'(held));
          have_held = 1'b0;
        end
        if (stall4) begin
          if (out_valid) begin
            stall++;
            out_ready = stall > 4;
          end else begin
            stall = 0;
            out_ready = 1'b0;
          end
        end else begin
          out_ready = 1'($urandom_range(0, 1));
        end
        if (out_valid && out_ready) begin
          check("rd_data", 32'(out_data), 32'(ref_mem[16'(int'(b) + idx)]));
          idx++;
        end else if (out_valid) begin
          held = out_data;
          have_held = 1'b1;
        end
      end
    end
    in_valid = 1'b0; out_ready = 1'b0; start = 1'b0;
    check("done_cnt", 32'(done_cnt), 32'd1);
    check("err", 32'(error), 32'(exp_err));
    if (dry) begin
      check("no_strobe", 32'(strobe_cyc), 32'd0);
      check("done_lat", 32'(done_cyc), 32'd2);
    end else if (hang) begin
      check("tmo_strobe_cyc", 32'(strobe_cyc), 32'(TIMEOUT));
    end else if (!d) begin
      check("wr_count", 32'(acc.size()), 32'(l));
      for (int i = 0; i < acc.size(); i++) begin
        check("wr_ram", 32'(tb_ram[16'(int'(b) + i)]), 32'(acc[i]));
        ref_mem[16'(int'(b) + i)] = acc[i];
      end
    end else begin
      check("rd_count", 32'(idx), 32'(l));
    end
    $display("burst dir=%0d base=0x%04h len=%0d err=%0d cycles=%0d", d, b, l, error, cyc);
  endtask

  initial begin
    logic [7:0] acc5[$];
    logic [15:0] b5;
    int guard;
    for (int i = 0; i < 65536; i++) ref_mem[i] = pat(i);

    // Reset state
    RST = 1'b0;
    repeat (3) @(negedge clk);
    all_zero("reset");
    RST = 1'b1;

    // 1: write A1,B2,C3 to 0x100
    run_burst(1'b0, 16'h0100, 16'd3, 1'b0, 1'b0, 1'b1);
    check("ram_100", 32'(tb_ram[16'h0100]), 32'hA1);
    check("ram_101", 32'(tb_ram[16'h0101]), 32'hB2);
    check("ram_102", 32'(tb_ram[16'h0102]), 32'hC3);

    // 2: read back with a slow consumer
    run_burst(1'b1, 16'h0100, 16'd3, 1'b0, 1'b1, 1'b0);

    // 3: empty burst, out-of-range burst, burst ending exactly at the top
    run_burst(1'b0, 16'h1234, 16'd0, 1'b0, 1'b0, 1'b0);
    run_burst(1'b1, 16'h7FFF, 16'd2, 1'b0, 1'b0, 1'b0);
    run_burst(1'b0, 16'h7FFE, 16'd2, 1'b0, 1'b0, 1'b0);
    run_burst(1'b1, 16'h7FFE, 16'd2, 1'b0, 1'b0, 1'b0);

    // 4: RAM never answers a write
    hang = 1'b1;
    run_burst(1'b0, 16'h0200, 16'd1, 1'b0, 1'b0, 1'b0);
    hang = 1'b0;
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(error), 32'd1);

    // 5: reset while the second of four writes is pending
    fixed_lat = 3;
    b5 = 16'h0400;
    @(negedge clk);
    dir = 1'b0; base_addr = b5; length = 16'd4; start = 1'b1;
    guard = 0;
    while (1) begin
      @(negedge clk);
      start = 1'b0;
      guard++;
      in_valid = 1'b1;
      in_data  = 8'($urandom);
      if (in_valid && in_ready) acc5.push_back(in_data);
      if (acc5.size() == 2 && mem_write_signal) begin
        RST = 1'b0;
        break;
      end
      if (guard > 200) begin
        check("rst_mid_bound", 32'd0, 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
    @(negedge clk);
    all_zero("rst_mid");
    RST = 1'b1;
    fixed_lat = -1;
    if (acc5.size() == 2) begin
      check("rst_byte0", 32'(tb_ram[b5]), 32'(acc5[0]));
      check("rst_byte1_untouched", 32'(tb_ram[b5 + 16'd1]), 32'(ref_mem[b5 + 16'd1]));
      ref_mem[b5] = acc5[0];
    end
    $display("burst dir=0 base=0x%04h len=4 aborted by reset after %0d bytes", b5, acc5.size());
    run_burst(1'b0, b5, 16'd4, 1'b0, 1'b0, 1'b0);

    // 6: spurious start strobes and in_valid held high during a read
    run_burst(1'b1, b5, 16'd4, 1'b1, 1'b0, 1'b0);
    repeat (2) @(negedge clk);
    check("no_restart", 32'(busy), 32'd0);

    // Randomised bursts
    for (int t = 0; t < 40; t++) begin
      logic [15:0] rb, rl;
      bit rd;
      rd = 1'($urandom_range(0, 1));
      rl = 16'($urandom_range(0, 8));
      if ($urandom_range(0, 7) == 0) rb = 16'(MEM_DEPTH - int'($urandom_range(0, 6)));
      else                           rb = 16'($urandom_range(0, MEM_DEPTH - 16));
      run_burst(rd, rb, rl, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
